// File: rtl/scrambler_pkg.sv
// Shared constants, mode encoding and parameter sanity check for the LFSR
// scrambler family.
package scrambler_pkg;

  // Tap masks: bit i set means s[i] feeds the XOR, so x^n maps to bit n-1.
  localparam logic [6:0]  POLY_7  = 7'h60;
  localparam logic [6:0]  SEED_7  = 7'h7F;
  localparam logic [57:0] POLY_58 = (58'd1 << 57) | (58'd1 << 38);
  localparam logic [57:0] SEED_58 = {58{1'b1}};

  typedef enum logic [1:0] {
    MODE_ADDITIVE,
    MODE_MULT_SCR,
    MODE_MULT_DESCR
  } mode_e;

  function automatic bit width_ok(input int data_w, input int lfsr_w);
    return (data_w >= 1) && (lfsr_w >= 2);
  endfunction

endpackage

// File: rtl/lfsr_step_unroll.sv
// Combinational DATA_W-bit unroll of one LFSR scrambler step, LSB first.
// Reusable wherever a per-beat keystream/self-sync step is needed.
module lfsr_step_unroll
  import scrambler_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = 7,
  parameter logic [LFSR_W-1:0] POLY   = POLY_7
) (
  input  logic [LFSR_W-1:0] state,
  input  logic [DATA_W-1:0] data,
  input  mode_e             mode,
  output logic [LFSR_W-1:0] next_state,
  output logic [DATA_W-1:0] out_data
);

  logic [LFSR_W-1:0] s;
  logic              fb;
  logic              x;

  // NOTE: blocking assignments here are deliberate; each loop pass must see
  // the state produced by the previous bit-step within the same evaluation.
  always_comb begin
    s        = state;
    fb       = 1'b0;
    x        = 1'b0;
    out_data = '0;
    for (int k = 0; k < DATA_W; k++) begin
      fb          = ^(s & POLY);
      out_data[k] = data[k] ^ fb;
      case (mode)
        MODE_ADDITIVE: x = fb;
        MODE_MULT_SCR: x = out_data[k];
        default:       x = data[k];
      endcase
      s = {s[LFSR_W-2:0], x};
    end
    next_state = s;
  end

endmodule

// File: rtl/lfsr_scrambler.sv
// Streaming LFSR scrambler/descrambler with valid/ready handshake, one beat
// per clock, one-cycle latency, bypass and seed reload.
module lfsr_scrambler
  import scrambler_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                LFSR_W   = 7,
  parameter logic [LFSR_W-1:0] POLY     = POLY_7,
  parameter logic [LFSR_W-1:0] SEED     = SEED_7,
  parameter bit                ADDITIVE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  input  logic              descramble,
  input  logic              bypass,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_value,
  output logic [LFSR_W-1:0] lfsr_state
);

  if (!width_ok(DATA_W, LFSR_W)) begin : g_bad_width
    $error("lfsr_scrambler: DATA_W must be >= 1 and LFSR_W >= 2");
  end

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] base_state;
  logic [LFSR_W-1:0] step_state;
  logic [DATA_W-1:0] step_out;
  logic              accept;
  mode_e             mode;

  assign s_ready    = !m_valid || m_ready;
  assign accept     = s_valid && s_ready;
  assign lfsr_state = state;

  // A coincident seed_load seeds the beat being processed in the same cycle.
  assign base_state = seed_load ? seed_value : state;
  assign mode       = ADDITIVE ? MODE_ADDITIVE
                    : (descramble ? MODE_MULT_DESCR : MODE_MULT_SCR);

  lfsr_step_unroll #(
    .DATA_W (DATA_W),
    .LFSR_W (LFSR_W),
    .POLY   (POLY)
  ) u_step (
    .state      (base_state),
    .data       (s_data),
    .mode       (mode),
    .next_state (step_state),
    .out_data   (step_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (accept && !bypass) begin
      state <= step_state;
    end else if (seed_load) begin
      state <= seed_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= bypass ? s_data : step_out;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_scrambler.sv
// Scoreboard bench: directed vectors on a default additive instance, plus
// additive round-trip and multiplicative self-sync instance pairs.
module tb_lfsr_scrambler;
  import scrambler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- main DUT (default additive) ----------------
  logic       s_valid = 1'b0, m_ready = 1'b1;
  logic       descramble = 1'b0, bypass = 1'b0, seed_load = 1'b0;
  logic [7:0] s_data = '0;
  logic [6:0] seed_value = '0;
  logic       s_ready, m_valid;
  logic [7:0] m_data;
  logic [6:0] lfsr_state;
  logic [7:0] exp_q[$];

  lfsr_scrambler u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .descramble(descramble),
    .bypass(bypass), .seed_load(seed_load), .seed_value(seed_value), .lfsr_state(lfsr_state)
  );

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) check("main_extra_beat", 32'(m_data), 32'hFFFF_FFFF);
      else check("main_m_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- additive round trip A -> B ----------------
  logic       rt_s_valid = 1'b0;
  logic [7:0] rt_s_data = '0;
  logic       rt_a_ready, rt_ab_valid, rt_ab_ready, rt_m_valid;
  logic [7:0] rt_ab_data, rt_m_data;
  logic [6:0] rt_a_state, rt_b_state;
  logic [7:0] rt_q[$];

  lfsr_scrambler u_rt_a (
    .clk(clk), .rst(rst), .s_valid(rt_s_valid), .s_ready(rt_a_ready), .s_data(rt_s_data),
    .m_valid(rt_ab_valid), .m_ready(rt_ab_ready), .m_data(rt_ab_data), .descramble(1'b0),
    .bypass(1'b0), .seed_load(1'b0), .seed_value(7'h00), .lfsr_state(rt_a_state)
  );
  lfsr_scrambler u_rt_b (
    .clk(clk), .rst(rst), .s_valid(rt_ab_valid), .s_ready(rt_ab_ready), .s_data(rt_ab_data),
    .m_valid(rt_m_valid), .m_ready(1'b1), .m_data(rt_m_data), .descramble(1'b0),
    .bypass(1'b0), .seed_load(1'b0), .seed_value(7'h00), .lfsr_state(rt_b_state)
  );

  always @(negedge clk) begin
    if (!rst && rt_m_valid) begin
      if (rt_q.size() == 0) check("rt_extra_beat", 32'(rt_m_data), 32'hFFFF_FFFF);
      else check("rt_round_trip", 32'(rt_m_data), 32'(rt_q.pop_front()));
    end
  end

  // ---------------- multiplicative self-sync pair ----------------
  logic       ms_s_valid = 1'b0;
  logic [7:0] ms_s_data = '0;
  logic       ms_ready, ms_valid, md_ready, md_valid;
  logic [7:0] ms_data, md_data;
  logic [6:0] ms_state, md_state;
  logic [7:0] mult_q[$];
  int         mult_idx = 0;

  lfsr_scrambler #(.ADDITIVE(1'b0), .SEED(7'h7F)) u_ms (
    .clk(clk), .rst(rst), .s_valid(ms_s_valid), .s_ready(ms_ready), .s_data(ms_s_data),
    .m_valid(ms_valid), .m_ready(md_ready), .m_data(ms_data), .descramble(1'b0),
    .bypass(1'b0), .seed_load(1'b0), .seed_value(7'h00), .lfsr_state(ms_state)
  );
  lfsr_scrambler #(.ADDITIVE(1'b0), .SEED(7'h00)) u_md (
    .clk(clk), .rst(rst), .s_valid(ms_valid), .s_ready(md_ready), .s_data(ms_data),
    .m_valid(md_valid), .m_ready(1'b1), .m_data(md_data), .descramble(1'b1),
    .bypass(1'b0), .seed_load(1'b0), .seed_value(7'h00), .lfsr_state(md_state)
  );

  always @(negedge clk) begin
    if (!rst && md_valid) begin
      if (mult_q.size() == 0) begin
        check("mult_extra_beat", 32'(md_data), 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = mult_q.pop_front();
        if (mult_idx > 0) check("mult_self_sync", 32'(md_data), 32'(e));
        mult_idx++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d, input logic [7:0] e, input bit push,
                      input bit byp, input bit sl, input logic [6:0] sv, input bit desc);
    int t;
    s_data = d; bypass = byp; seed_load = sl; seed_value = sv; descramble = desc;
    s_valid = 1'b1;
    if (push) exp_q.push_back(e);
    t = 0;
    while (!s_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!s_ready) check("send_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; bypass = 1'b0; seed_load = 1'b0; descramble = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec %0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    check("reset_m_valid", 32'(m_valid), 32'd0);
    check("reset_m_data", 32'(m_data), 32'h00);
    check("reset_state", 32'(lfsr_state), 32'h7F);
    check("reset_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;

    // Additive keystream; descramble is ignored in additive mode.
    send(8'h00, 8'h40, 1, 0, 0, 7'h00, 1);
    check("ks1_state", 32'(lfsr_state), 32'h02);
    send(8'h00, 8'h30, 1, 0, 0, 7'h00, 0);
    check("ks2_state", 32'(lfsr_state), 32'h0C);
    repeat (2) @(posedge clk);

    // Backpressure: one beat held, the next stalled for 5 cycles.
    pulse_reset();
    m_ready = 1'b0;
    send(8'h00, 8'h40, 1, 0, 0, 7'h00, 0);
    s_data = 8'h00; s_valid = 1'b1;
    exp_q.push_back(8'h30);
    for (int i = 0; i < 5; i++) begin
      check("bp_s_ready", 32'(s_ready), 32'd0);
      check("bp_m_data_stable", 32'(m_data), 32'h40);
      check("bp_state_frozen", 32'(lfsr_state), 32'h02);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("bp_release_state", 32'(lfsr_state), 32'h0C);
    repeat (2) @(posedge clk); #1;
    check("bp_queue_drained", 32'(exp_q.size()), 32'd0);

    // Seed reload coincident with a beat, then bypass, then normal beat.
    send(8'h00, 8'h40, 1, 0, 1, 7'h7F, 0);
    check("seed_beat_state", 32'(lfsr_state), 32'h02);
    send(8'hA5, 8'hA5, 1, 1, 0, 7'h00, 0);
    check("bypass_state", 32'(lfsr_state), 32'h02);
    send(8'h00, 8'h30, 1, 0, 0, 7'h00, 0);
    check("post_bypass_state", 32'(lfsr_state), 32'h0C);

    // Additive all-zero lock-up: output equals input, state stays 0.
    send(8'h5A, 8'h5A, 1, 0, 1, 7'h00, 0);
    check("lockup_state1", 32'(lfsr_state), 32'h00);
    send(8'h3C, 8'h3C, 1, 0, 0, 7'h00, 0);
    check("lockup_state2", 32'(lfsr_state), 32'h00);
    repeat (2) @(posedge clk);

    // Async reset while a beat is held.
    m_ready = 1'b0;
    send(8'h11, 8'h00, 0, 0, 0, 7'h00, 0);
    check("stall_m_valid", 32'(m_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_m_valid", 32'(m_valid), 32'd0);
    check("async_rst_m_data", 32'(m_data), 32'h00);
    check("async_rst_state", 32'(lfsr_state), 32'h7F);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    send(8'h00, 8'h40, 1, 0, 0, 7'h00, 0);
    check("after_rst_state", 32'(lfsr_state), 32'h02);
    repeat (3) @(posedge clk); #1;
    check("main_queue_drained", 32'(exp_q.size()), 32'd0);

    // Additive round trip through two instances.
    for (int i = 0; i < 256; i++) begin
      rt_s_data = 8'($urandom);
      rt_s_valid = 1'b1;
      if (rt_a_ready) rt_q.push_back(rt_s_data);
      else check("rt_a_ready", 32'(rt_a_ready), 32'd1);
      @(posedge clk); #1;
    end
    rt_s_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("rt_queue_drained", 32'(rt_q.size()), 32'd0);

    // Multiplicative scrambler -> descrambler with mismatched seeds.
    for (int i = 0; i < 32; i++) begin
      ms_s_data = 8'($urandom);
      ms_s_valid = 1'b1;
      if (ms_ready) mult_q.push_back(ms_s_data);
      else check("ms_ready", 32'(ms_ready), 32'd1);
      @(posedge clk); #1;
    end
    ms_s_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("mult_queue_drained", 32'(mult_q.size()), 32'd0);
    check("mult_beats_seen", 32'(mult_idx), 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_scrambler.md
Name: lfsr_scrambler

Overview:
- Parametrised LFSR scrambler/descrambler on a streaming byte/word path with valid/ready handshake, one beat per clock.
- Supports additive (synchronous) and multiplicative (self-synchronising) modes, runtime scramble/descramble selection, bypass and seed reload.
- Sits between the framing logic and the serialiser (TX), or deserialiser and deframer (RX).
- Next generation of our fixed 8-bit shift/XOR scrambler.

Parameters:
- DATA_W, 8, beat width in bits; must be >= 1.
- LFSR_W, 7, LFSR state width; must be >= 2.
- POLY, 7'h60, tap mask over state bits; bit i set means s[i] feeds the XOR (7'h60 = x^7+x^6+1).
- SEED, 7'h7F, reset value of state; must be nonzero in additive mode.
- ADDITIVE, 1, 1 = additive keystream; 0 = multiplicative.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept a beat.
- s_data  in  DATA_W  input beat.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_W  output beat.
- descramble  in  1  multiplicative mode only: 0 = scramble, 1 = descramble; ignored when ADDITIVE=1.
- bypass  in  1  pass data unchanged, state frozen.
- seed_load  in  1  single-cycle pulse: load seed_value into state.
- seed_value  in  LFSR_W  seed for seed_load.
- lfsr_state  out  LFSR_W  current state (debug/verification).

Behaviour:
- Reset (async assert, sync deassert by the user): m_valid=0, m_data=0, state=SEED, lfsr_state=SEED, s_ready=1.
- Handshake: s_ready = !m_valid || m_ready. A beat is accepted when s_valid && s_ready.
- Output register: m_data/m_valid update on acceptance. Latency is 1 cycle; throughput is 1 beat/cycle under continuous m_ready.
- m_valid holds and m_data is stable while m_valid && !m_ready. m_valid clears when m_ready=1 with no new acceptance.
- Per accepted beat, DATA_W bit-steps are unrolled combinationally, processed LSB first (d = s_data[k], k = 0..DATA_W-1).
- Each bit-step computes fb = XOR(s & POLY), then out[k] = d ^ fb. State update, s <= {s[LFSR_W-2:0], x}:
  - additive: x = fb;
  - multiplicative scramble: x = out[k];
  - multiplicative descramble: x = d.
- State register takes the value after step DATA_W-1. State changes only on an accepted beat.
- Bypass: on an accepted beat with bypass=1, m_data = s_data and the state is unchanged.
- seed_load: state <= seed_value.
- seed_load with a simultaneous accepted beat: the beat is processed starting from seed_value, and the state advances from it.
- seed_load while output is stalled: the state is loaded; the pending m_data is unaffected.
- descramble/bypass are sampled only on acceptance; changing them mid-stall has no effect on the held beat.
- Additive all-zero state is a lock-up. The block does not correct it; seed_value=0 in additive mode is a user error. The bench checks that the state stays 0 and the output equals the input.
- Reset mid-stream: the held beat is discarded; state returns to SEED.

Decomposition:
- Package scrambler_pkg: default POLY/SEED constants (x^7+x^6+1, x^58+x^39+1), a mode enum (ADDITIVE, MULT_SCR, MULT_DESCR), and a width-check function.
- One natural sub-module: lfsr_step_unroll.
  - Purely combinational: inputs state, data, mode; outputs next_state and out_data.
  - Parametrised by DATA_W/LFSR_W/POLY.
  - Reusable by a future PRBS checker.
- lfsr_scrambler owns the handshake, output register, state register and seed/bypass muxing.

Test Plan:
- Additive keystream, default params: after reset, send s_data=8'h00 -> m_data=8'h40 one cycle later, lfsr_state=7'h02. Next 8'h00 -> m_data=8'h30, state=7'h0C.
- Additive round trip: two instances with SEED 7'h7F, 256 random beats through A then B -> B output equals the original stream.
- Multiplicative self-sync: the scrambler's seed is 7'h7F and the descrambler's seed is 7'h00, with ADDITIVE=0. After the first beat (>= LFSR_W bits), descrambler output equals the original data for every subsequent beat.
- Backpressure: hold m_ready=0 for 5 cycles with s_valid=1 -> s_ready=0, m_data stable, state unchanged. On release, beats emerge in order with none lost or duplicated.
- Seed/bypass: seed_load with seed_value=7'h7F coincident with beat 8'h00 -> m_data=8'h40. Bypass beat 8'hA5 -> m_data=8'hA5 and lfsr_state unchanged.
- Async reset mid-stall: assert rst while m_valid=1 -> m_valid=0 immediately, lfsr_state=7'h7F. The first beat after reset reproduces the first-beat vector.
